bp_writeback_scheduler: RTL and testbench

//  Sequences the BP->DDR write-back path for one layer output. Accepts one job descriptor and splits it

---
 rtl/bp_wb_pkg.sv | 20 ++
 rtl/bp_wb_addr_gen.sv | 34 +++
 rtl/bp_writeback_scheduler.sv | 188 ++++++++++++++++++
 tb/tb_bp_writeback_scheduler.sv | 379 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bp_wb_pkg.sv
// Shared definitions for the BP->DDR write-back scheduler: FSM state
// encoding and the fixed beat/tile geometry.
package bp_wb_pkg;

   // log2 of bytes per 512-bit DDR beat (64 B)
   localparam int BEAT_SHIFT     = 6;
   // each tile carries two BP lines, one from each MAC group of a pair
   localparam int LINES_PER_TILE = 2;

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_LOAD  = 3'd1,
      S_CONF  = 3'd2,
      S_GUARD = 3'd3,
      S_WAIT  = 3'd4,
      S_NEXT  = 3'd5,
      S_DONE  = 3'd6
   } wb_state_e;

endpackage

// File: rtl/bp_wb_addr_gen.sv
// Tile-to-tile address stepping. Purely combinational so it can be
// exercised on its own: DDR address advances by the stride, the MAC
// group pair base advances by two, and the BP line address moves on by
// one line width whenever the pair base wraps past group 3.
module bp_wb_addr_gen
   import bp_wb_pkg::*;
#(
   parameter int DDR_ADDR_LEN = 32,
   parameter int ADDR_LEN     = 16,
   parameter int SINGLE_LEN   = 24
) (
   input  logic [DDR_ADDR_LEN-1:0] i_ddr_addr,
   input  logic [DDR_ADDR_LEN-1:0] i_stride,
   input  logic [ADDR_LEN-1:0]     i_bp_addr,
   input  logic [1:0]              i_bp_num,
   input  logic [SINGLE_LEN-1:0]   i_line_width,
   output logic [DDR_ADDR_LEN-1:0] o_ddr_addr,
   output logic [ADDR_LEN-1:0]     o_bp_addr,
   output logic [1:0]              o_bp_num
);

   logic [ADDR_LEN-1:0] w_lw_step;

   // line width folded into the BP address width (wraps modulo 2^ADDR_LEN)
   assign w_lw_step = ADDR_LEN'(i_line_width);

   // next-tile arithmetic; a pair base of 2 or 3 means the pair wraps
   always_comb begin
      o_ddr_addr = i_ddr_addr + i_stride;
      o_bp_num   = i_bp_num + 2'd2;
      o_bp_addr  = i_bp_num[1] ? (i_bp_addr + w_lw_step) : i_bp_addr;
   end

endmodule

// File: rtl/bp_writeback_scheduler.sv
// Write-back scheduler: takes one layer-output job descriptor, splits it
// into tiles of two BP lines, and for each tile configures the BP write
// controller, lets it start, waits for it to drain, then steps addresses.
//
// Job handshake: a descriptor transfers on a rising clk edge where
// job_valid and job_ready are both high. job_ready is high only in IDLE;
// job_valid in any other state is ignored and never queued.
module bp_writeback_scheduler
   import bp_wb_pkg::*;
#(
   parameter int DDR_ADDR_LEN = 32,
   parameter int ADDR_LEN     = 16,
   parameter int SINGLE_LEN   = 24,
   parameter int TILE_LEN     = 16,
   parameter int START_GUARD  = 2
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    job_valid,
   output logic                    job_ready,
   input  logic [DDR_ADDR_LEN-1:0] job_ddr_base,
   input  logic [DDR_ADDR_LEN-1:0] job_ddr_stride,
   input  logic [TILE_LEN-1:0]     job_tile_cnt,
   input  logic [SINGLE_LEN-1:0]   job_line_width,
   input  logic [ADDR_LEN-1:0]     job_bp_st_addr,
   input  logic [1:0]              job_bp_st_num,
   output logic                    wr_conf,
   output logic [DDR_ADDR_LEN-1:0] wr_ddr_st_addr,
   output logic [SINGLE_LEN-1:0]   wr_data_ddr_byte,
   output logic [ADDR_LEN-1:0]     wr_bp_st_addr,
   output logic [1:0]              wr_bp_st_num,
   output logic [SINGLE_LEN-1:0]   wr_line_width,
   input  logic                    wr_idle,
   output logic                    busy,
   output logic [TILE_LEN-1:0]     tile_idx,
   output logic                    done,
   output logic                    err,
   output logic [2:0]              dbg_state
);

   localparam logic [7:0] GUARD_LAST = 8'(START_GUARD - 1);

   wb_state_e                r_state;
   wb_state_e                w_state_nxt;

   logic [DDR_ADDR_LEN-1:0]  r_stride;
   logic [TILE_LEN-1:0]      r_tile_cnt;
   logic [TILE_LEN-1:0]      r_tile_idx;
   logic [DDR_ADDR_LEN-1:0]  r_wr_ddr_st_addr;
   logic [SINGLE_LEN-1:0]    r_wr_data_ddr_byte;
   logic [ADDR_LEN-1:0]      r_wr_bp_st_addr;
   logic [1:0]               r_wr_bp_st_num;
   logic [SINGLE_LEN-1:0]    r_wr_line_width;
   logic [7:0]               r_guard_cnt;
   logic                     r_err;

   logic                     w_last;
   logic                     w_job_empty;
   logic [DDR_ADDR_LEN-1:0]  w_nxt_ddr;
   logic [ADDR_LEN-1:0]      w_nxt_bp_addr;
   logic [1:0]               w_nxt_bp_num;

   assign w_last      = (r_tile_idx == (r_tile_cnt - TILE_LEN'(1)));
   assign w_job_empty = (r_tile_cnt == '0) || (r_wr_line_width == '0);

   bp_wb_addr_gen #(
      .DDR_ADDR_LEN (DDR_ADDR_LEN),
      .ADDR_LEN     (ADDR_LEN),
      .SINGLE_LEN   (SINGLE_LEN)
   ) u_addr_gen (
      .i_ddr_addr   (r_wr_ddr_st_addr),
      .i_stride     (r_stride),
      .i_bp_addr    (r_wr_bp_st_addr),
      .i_bp_num     (r_wr_bp_st_num),
      .i_line_width (r_wr_line_width),
      .o_ddr_addr   (w_nxt_ddr),
      .o_bp_addr    (w_nxt_bp_addr),
      .o_bp_num     (w_nxt_bp_num)
   );

   // state register
   always_ff @(posedge clk) begin
      if (!rst_n) r_state <= S_IDLE;
      else        r_state <= w_state_nxt;
   end

   // next-state decode and state-derived outputs
   always_comb begin
      w_state_nxt = r_state;
      job_ready   = 1'b0;
      busy        = 1'b1;
      wr_conf     = 1'b0;
      done        = 1'b0;
      case (r_state)
         S_IDLE: begin
            job_ready = 1'b1;
            busy      = 1'b0;
            if (job_valid) w_state_nxt = S_LOAD;
         end
         S_LOAD: begin
            w_state_nxt = w_job_empty ? S_DONE : S_CONF;
         end
         S_CONF: begin
            wr_conf     = 1'b1;
            w_state_nxt = S_GUARD;
         end
         S_GUARD: begin
            if (r_guard_cnt == GUARD_LAST) w_state_nxt = S_WAIT;
         end
         S_WAIT: begin
            if (wr_idle) w_state_nxt = w_last ? S_DONE : S_NEXT;
         end
         S_NEXT: begin
            w_state_nxt = S_CONF;
         end
         S_DONE: begin
            done        = 1'b1;
            w_state_nxt = S_IDLE;
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   // job capture, tile stepping and guard timing; the wr_* fields change
   // on entry to LOAD/NEXT so they are settled a cycle ahead of wr_conf
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_stride           <= '0;
         r_tile_cnt         <= '0;
         r_tile_idx         <= '0;
         r_wr_ddr_st_addr   <= '0;
         r_wr_data_ddr_byte <= '0;
         r_wr_bp_st_addr    <= '0;
         r_wr_bp_st_num     <= '0;
         r_wr_line_width    <= '0;
         r_guard_cnt        <= '0;
         r_err              <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (job_valid) begin
                  r_stride           <= job_ddr_stride;
                  r_tile_cnt         <= job_tile_cnt;
                  r_tile_idx         <= '0;
                  r_wr_ddr_st_addr   <= job_ddr_base;
                  r_wr_data_ddr_byte <= job_line_width << (BEAT_SHIFT + $clog2(LINES_PER_TILE));
                  r_wr_bp_st_addr    <= job_bp_st_addr;
                  r_wr_bp_st_num     <= job_bp_st_num;
                  r_wr_line_width    <= job_line_width;
                  r_err              <= 1'b0;
               end
            end
            S_LOAD: begin
               // an empty job is not an error; a zero line width is
               r_err <= (r_tile_cnt != '0) && (r_wr_line_width == '0);
            end
            S_CONF: begin
               r_guard_cnt <= '0;
            end
            S_GUARD: begin
               r_guard_cnt <= r_guard_cnt + 8'd1;
            end
            S_WAIT: begin
               if (wr_idle && !w_last) begin
                  r_tile_idx       <= r_tile_idx + TILE_LEN'(1);
                  r_wr_ddr_st_addr <= w_nxt_ddr;
                  r_wr_bp_st_addr  <= w_nxt_bp_addr;
                  r_wr_bp_st_num   <= w_nxt_bp_num;
               end
            end
            default: begin
            end
         endcase
      end
   end

   assign wr_ddr_st_addr   = r_wr_ddr_st_addr;
   assign wr_data_ddr_byte = r_wr_data_ddr_byte;
   assign wr_bp_st_addr    = r_wr_bp_st_addr;
   assign wr_bp_st_num     = r_wr_bp_st_num;
   assign wr_line_width    = r_wr_line_width;
   assign tile_idx         = r_tile_idx;
   assign err              = done & r_err;
   assign dbg_state        = r_state;

endmodule

// File: tb/tb_bp_writeback_scheduler.sv
// Bench for the write-back scheduler: a writer model answers each conf
// pulse, a monitor records every conf/done, and each job's expected conf
// list (cycle, addresses, group pair) is computed in closed form.
module tb_bp_writeback_scheduler;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        job_valid;
  logic        job_ready;
  logic [31:0] job_ddr_base;
  logic [31:0] job_ddr_stride;
  logic [15:0] job_tile_cnt;
  logic [23:0] job_line_width;
  logic [15:0] job_bp_st_addr;
  logic [1:0]  job_bp_st_num;
  logic        wr_conf;
  logic [31:0] wr_ddr_st_addr;
  logic [23:0] wr_data_ddr_byte;
  logic [15:0] wr_bp_st_addr;
  logic [1:0]  wr_bp_st_num;
  logic [23:0] wr_line_width;
  logic        wr_idle;
  logic        busy;
  logic [15:0] tile_idx;
  logic        done;
  logic        err;
  logic [2:0]  dbg_state;

  typedef struct packed {
    logic [31:0] at;
    logic [31:0] ddr;
    logic [23:0] nbyte;
    logic [15:0] addr;
    logic [1:0]  num;
    logic [15:0] tile;
    logic [23:0] lw;
  } conf_t;

  conf_t exp_q[$];
  conf_t obs_q[$];
  int    done_cyc_q[$];
  logic  done_err_q[$];

  int cyc = 0;
  int errors = 0;
  int checks = 0;
  int wr_low_len = 0;

  bp_writeback_scheduler dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .job_valid        (job_valid),
    .job_ready        (job_ready),
    .job_ddr_base     (job_ddr_base),
    .job_ddr_stride   (job_ddr_stride),
    .job_tile_cnt     (job_tile_cnt),
    .job_line_width   (job_line_width),
    .job_bp_st_addr   (job_bp_st_addr),
    .job_bp_st_num    (job_bp_st_num),
    .wr_conf          (wr_conf),
    .wr_ddr_st_addr   (wr_ddr_st_addr),
    .wr_data_ddr_byte (wr_data_ddr_byte),
    .wr_bp_st_addr    (wr_bp_st_addr),
    .wr_bp_st_num     (wr_bp_st_num),
    .wr_line_width    (wr_line_width),
    .wr_idle          (wr_idle),
    .busy             (busy),
    .tile_idx         (tile_idx),
    .done             (done),
    .err              (err),
    .dbg_state        (dbg_state)
  );

  // clock / cycle counter
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // monitor: record conf pulses and done pulses with their cycle
  always @(negedge clk) begin
    if (wr_conf === 1'b1)
      obs_q.push_back('{at: 32'(cyc), ddr: wr_ddr_st_addr, nbyte: wr_data_ddr_byte,
                        addr: wr_bp_st_addr, num: wr_bp_st_num, tile: tile_idx, lw: wr_line_width});
    if (done === 1'b1) begin
      done_cyc_q.push_back(cyc);
      done_err_q.push_back(err);
    end
  end

  // writer model: idle stays high one cycle after conf, then low wr_low_len cycles
  initial begin
    wr_idle = 1'b1;
    forever begin
      @(negedge clk);
      if (wr_conf === 1'b1) begin
        @(negedge clk);
        if (wr_low_len != 0) begin
          @(negedge clk);
          wr_idle = 1'b0;
          repeat (wr_low_len) @(negedge clk);
          wr_idle = 1'b1;
        end
      end
    end
  end

  task automatic clear_logs();
    exp_q.delete();
    obs_q.delete();
    done_cyc_q.delete();
    done_err_q.delete();
  endtask

  // driver: present a descriptor in IDLE, optionally keep job_valid high afterwards
  task automatic drive_job(input logic [31:0] base, input logic [31:0] stride,
                           input logic [15:0] tiles, input logic [23:0] lw,
                           input logic [15:0] addr, input logic [1:0] num,
                           input int hold, output int hs);
    int w;
    w = 0;
    @(negedge clk);
    while (job_ready !== 1'b1 && w < 200) begin
      @(negedge clk);
      w++;
    end
    checks++;
    if (job_ready !== 1'b1) begin
      errors++;
      $display("FAIL job_ready_wait got=%b exp=1", job_ready);
    end
    job_ddr_base   = base;
    job_ddr_stride = stride;
    job_tile_cnt   = tiles;
    job_line_width = lw;
    job_bp_st_addr = addr;
    job_bp_st_num  = num;
    job_valid      = 1'b1;
    hs = cyc;
    @(negedge clk);
    checks++;
    if (job_ready !== 1'b0) begin
      errors++;
      $display("FAIL job_ready_drop got=%b exp=0", job_ready);
    end
    if (hold > 0) begin
      job_ddr_base   = $urandom;
      job_ddr_stride = $urandom;
      job_tile_cnt   = 16'($urandom_range(1, 9));
      job_line_width = 24'($urandom_range(1, 500));
      job_bp_st_addr = 16'($urandom);
      job_bp_st_num  = 2'($urandom);
      repeat (hold) @(negedge clk);
    end
    job_valid = 1'b0;
  endtask

  // one complete job: build expectations, run, compare
  task automatic run_job(input string name, input logic [31:0] base, input logic [31:0] stride,
                         input logic [15:0] tiles, input logic [23:0] lw,
                         input logic [15:0] addr, input logic [1:0] num,
                         input int low, input int hold);
    int    hs, bound, w, exp_done, prev, n;
    logic  exp_err;
    conf_t e;
    conf_t o;
    clear_logs();
    wr_low_len = low;
    drive_job(base, stride, tiles, lw, addr, num, hold, hs);
    exp_err = (tiles != 0) && (lw == 0);
    exp_done = hs + 2;
    if (tiles != 0 && lw != 0) begin
      prev = 0;
      for (int t = 0; t < int'(tiles); t++) begin
        if (t == 0) e.at = 32'(hs + 2);
        else        e.at = 32'(((prev + 2 + low) > (prev + 3) ? (prev + 2 + low) : (prev + 3)) + 2);
        n       = int'(num) + 2 * t;
        e.ddr   = base + stride * 32'(t);
        e.nbyte = 24'(lw * 128);
        e.num   = 2'(n % 4);
        e.addr  = addr + 16'(int'(lw[15:0]) * (n / 4));
        e.tile  = 16'(t);
        e.lw    = lw;
        exp_q.push_back(e);
        prev = int'(e.at);
      end
      exp_done = ((prev + 2 + low) > (prev + 3) ? (prev + 2 + low) : (prev + 3)) + 1;
    end
    bound = int'(tiles) * (low + 12) + 40;
    w = 0;
    while (done_cyc_q.size() == 0 && w < bound) begin
      @(negedge clk);
      w++;
    end
    repeat (4) @(negedge clk);
    checks++;
    if (done_cyc_q.size() != 1) begin
      errors++;
      $display("FAIL %s done_count got=%0d exp=1", name, done_cyc_q.size());
    end
    checks++;
    if (obs_q.size() != exp_q.size()) begin
      errors++;
      $display("FAIL %s conf_count got=%0d exp=%0d", name, obs_q.size(), exp_q.size());
    end
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      o = obs_q[i];
      e = exp_q[i];
      checks++;
      if (o.at !== e.at) begin
        errors++;
        $display("FAIL %s conf_cycle tile=%0d got=%0d exp=%0d", name, i, o.at, e.at);
      end
      checks++;
      if (o.ddr !== e.ddr) begin
        errors++;
        $display("FAIL %s ddr_addr tile=%0d got=%08h exp=%08h", name, i, o.ddr, e.ddr);
      end
      checks++;
      if (o.nbyte !== e.nbyte) begin
        errors++;
        $display("FAIL %s data_byte tile=%0d got=%0d exp=%0d", name, i, o.nbyte, e.nbyte);
      end
      checks++;
      if (o.addr !== e.addr) begin
        errors++;
        $display("FAIL %s bp_addr tile=%0d got=%04h exp=%04h", name, i, o.addr, e.addr);
      end
      checks++;
      if (o.num !== e.num) begin
        errors++;
        $display("FAIL %s bp_num tile=%0d got=%0d exp=%0d", name, i, o.num, e.num);
      end
      checks++;
      if (o.tile !== e.tile) begin
        errors++;
        $display("FAIL %s tile_idx tile=%0d got=%0d exp=%0d", name, i, o.tile, e.tile);
      end
      checks++;
      if (o.lw !== e.lw) begin
        errors++;
        $display("FAIL %s line_width tile=%0d got=%0d exp=%0d", name, i, o.lw, e.lw);
      end
    end
    if (done_cyc_q.size() > 0) begin
      checks++;
      if (done_cyc_q[0] != exp_done) begin
        errors++;
        $display("FAIL %s done_cycle got=%0d exp=%0d", name, done_cyc_q[0], exp_done);
      end
      checks++;
      if (done_err_q[0] !== exp_err) begin
        errors++;
        $display("FAIL %s err got=%b exp=%b", name, done_err_q[0], exp_err);
      end
    end
    checks++;
    if (busy !== 1'b0 || job_ready !== 1'b1) begin
      errors++;
      $display("FAIL %s idle_after got=busy%b/ready%b exp=busy0/ready1", name, busy, job_ready);
    end
  endtask

  task automatic test_reset();
    rst_n          = 1'b0;
    job_valid      = 1'b0;
    job_ddr_base   = '0;
    job_ddr_stride = '0;
    job_tile_cnt   = '0;
    job_line_width = '0;
    job_bp_st_addr = '0;
    job_bp_st_num  = '0;
    repeat (3) @(negedge clk);
    checks++; if (job_ready !== 1'b1) begin errors++; $display("FAIL reset_job_ready got=%b exp=1", job_ready); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (wr_conf !== 1'b0) begin errors++; $display("FAIL reset_wr_conf got=%b exp=0", wr_conf); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got=%b exp=0", done); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err got=%b exp=0", err); end
    checks++; if (wr_ddr_st_addr !== 32'h0) begin errors++; $display("FAIL reset_ddr got=%h exp=0", wr_ddr_st_addr); end
    checks++; if (wr_data_ddr_byte !== 24'h0) begin errors++; $display("FAIL reset_byte got=%h exp=0", wr_data_ddr_byte); end
    checks++; if (wr_bp_st_addr !== 16'h0) begin errors++; $display("FAIL reset_bp_addr got=%h exp=0", wr_bp_st_addr); end
    checks++; if (wr_bp_st_num !== 2'd0) begin errors++; $display("FAIL reset_bp_num got=%h exp=0", wr_bp_st_num); end
    checks++; if (wr_line_width !== 24'h0) begin errors++; $display("FAIL reset_lw got=%h exp=0", wr_line_width); end
    checks++; if (tile_idx !== 16'h0) begin errors++; $display("FAIL reset_tile_idx got=%h exp=0", tile_idx); end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_basic();
    run_job("basic", 32'h1000, 32'h100, 16'd3, 24'd4, 16'h0, 2'd0, 3, 0);
  endtask

  task automatic test_empty_job();
    run_job("empty", 32'h2000, 32'h40, 16'd0, 24'd8, 16'h10, 2'd1, 2, 0);
  endtask

  task automatic test_zero_width();
    run_job("zero_lw", 32'h3000, 32'h80, 16'd5, 24'd0, 16'h20, 2'd2, 2, 0);
  endtask

  task automatic test_guard();
    run_job("slow_writer", 32'h4000, 32'h200, 16'd3, 24'd16, 16'h100, 2'd1, 20, 0);
    run_job("fast_writer", 32'h5000, 32'h10, 16'd3, 24'd2, 16'h8, 2'd2, 0, 0);
  endtask

  task automatic test_wrap();
    run_job("wrap", 32'hFFFF_FF80, 32'h100, 16'd2, 24'd7, 16'hFFFE, 2'd3, 1, 0);
  endtask

  task automatic test_valid_outside_idle();
    run_job("valid_held", 32'h6000, 32'h300, 16'd3, 24'd5, 16'h40, 2'd0, 2, 3);
  endtask

  task automatic test_reset_mid_job();
    int hs, w;
    clear_logs();
    wr_low_len = 10;
    drive_job(32'h7000, 32'h1000, 16'd4, 24'd3, 16'h0, 2'd0, 0, hs);
    w = 0;
    while (obs_q.size() < 2 && w < 200) begin
      @(negedge clk);
      w++;
    end
    checks++;
    if (obs_q.size() < 2) begin
      errors++;
      $display("FAIL rst_mid tile1_conf got=%0d exp=2", obs_q.size());
    end else begin
      checks++;
      if (obs_q[1].ddr !== 32'h8000) begin
        errors++;
        $display("FAIL rst_mid tile1_ddr got=%h exp=00008000", obs_q[1].ddr);
      end
    end
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    checks++; if (job_ready !== 1'b1) begin errors++; $display("FAIL rst_mid job_ready got=%b exp=1", job_ready); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_mid busy got=%b exp=0", busy); end
    checks++; if (tile_idx !== 16'h0) begin errors++; $display("FAIL rst_mid tile_idx got=%0d exp=0", tile_idx); end
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    checks++;
    if (done_cyc_q.size() != 0) begin
      errors++;
      $display("FAIL rst_mid done_pulse got=%0d exp=0", done_cyc_q.size());
    end
    run_job("after_rst", 32'h9000, 32'h20, 16'd2, 24'd9, 16'h30, 2'd2, 2, 0);
  endtask

  task automatic test_random();
    logic [15:0] tiles;
    for (int k = 0; k < 8; k++) begin
      tiles = 16'($urandom_range(1, 5));
      run_job("random", $urandom, $urandom, tiles, 24'($urandom_range(1, 131071)),
              16'($urandom), 2'($urandom), int'($urandom_range(0, 5)), int'($urandom_range(0, 2)));
    end
  endtask

  task automatic test_back_to_back();
    run_job("b2b_a", 32'hA000, 32'h40, 16'd1, 24'd1, 16'h0, 2'd3, 0, 0);
    run_job("b2b_b", 32'hB000, 32'h40, 16'd0, 24'd1, 16'h0, 2'd0, 0, 0);
    run_job("b2b_c", 32'hC000, 32'hFFFF_FFC0, 16'd4, 24'd1, 16'h5, 2'd3, 1, 0);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_empty_job();
    test_zero_width();
    test_guard();
    test_wrap();
    test_valid_outside_idle();
    test_reset_mid_job();
    test_random();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
